// File: rtl/gpib_listener.sv
// rtl/gpib_listener.sv - GPIB acceptor (listener) handshake with receive FIFO.
// Optional: define GPIB_LISTENER_ATN_FILTER_EN to drop command bytes instead of queuing them.
module gpib_listener #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dio_in,
  input  logic       dav_in,
  input  logic       atn_in,
  input  logic       listen_en,
  output logic       nrfd_out,
  output logic       ndac_out,
  output logic [7:0] rx_data,
  output logic       rx_cmd,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, READY, CAPTURE, ACCEPT} state_t;

  state_t        state;
  logic          dav_m, dav_s, atn_m, atn_s;
  logic [8:0]    cap_q;
  logic [TW-1:0] tcnt;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic [8:0]    head;
  logic          push, pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dav_m <= 1'b0;
      dav_s <= 1'b0;
      atn_m <= 1'b0;
      atn_s <= 1'b0;
    end else begin
      dav_m <= dav_in;
      dav_s <= dav_m;
      atn_m <= atn_in;
      atn_s <= atn_m;
    end
  end

  assign count    = wr_ptr - rd_ptr;
  assign rx_valid = (count != '0);
  assign pop      = rx_valid && rx_ready;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign rx_data  = head[7:0];

`ifdef GPIB_LISTENER_ATN_FILTER_EN
  assign push   = (state == CAPTURE) && !cap_q[8];
  assign rx_cmd = 1'b0;
`else
  assign push   = (state == CAPTURE);
  assign rx_cmd = head[8];
`endif

  // No overflow check on push: READY is only entered with a free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= cap_q;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HOLD;
      nrfd_out    <= 1'b1;
      ndac_out    <= 1'b1;
      timeout_err <= 1'b0;
      cap_q       <= '0;
      tcnt        <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        HOLD: begin
          if (listen_en && (count < DEPTH_C) && !dav_s) begin
            state    <= READY;
            nrfd_out <= 1'b0;
          end
        end
        READY: begin
          if (dav_s) begin
            state    <= CAPTURE;
            cap_q    <= {atn_s, dio_in};
            nrfd_out <= 1'b1;
          end else if (!listen_en) begin
            state    <= HOLD;
            nrfd_out <= 1'b1;
          end
        end
        CAPTURE: begin
          state    <= ACCEPT;
          ndac_out <= 1'b0;
          tcnt     <= '0;
        end
        ACCEPT: begin
          if (!dav_s) begin
            state    <= HOLD;
            ndac_out <= 1'b1;
          end else if (tcnt == T_LAST) begin
            // HOLD will not re-arm until dav_s drops, so a stuck talker is not re-captured.
            state       <= HOLD;
            ndac_out    <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state    <= HOLD;
          nrfd_out <= 1'b1;
          ndac_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/gpib_listener.md
# gpib_listener

Acceptor (listener) end of the GPIB three-wire handshake, opposite the bus talker that drives DAV and data. It synchronises the talker's DAV/ATN, drives NRFD/NDAC, captures each byte and queues it in a small receive FIFO for the local consumer. It flags commands (ATN asserted) and aborts a stalled handshake on timeout.

## Interface
- FIFO_DEPTH, 4: receive FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 1000: max cycles in ACCEPT waiting for DAV to drop; ≥2.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- dio_in  in  8  bus data from talker, positive logic.
- dav_in  in  1  data valid from talker, 1 = valid.
- atn_in  in  1  attention from controller, 1 = command byte.
- listen_en  in  1  1 = listener addressed/enabled.
- nrfd_out  out  1  not ready for data, 1 = not ready.
- ndac_out  out  1  not data accepted, 1 = not accepted.
- rx_data  out  8  FIFO head byte.
- rx_cmd  out  1  FIFO head was received with ATN=1.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer pop; pop when rx_valid && rx_ready.
- timeout_err  out  1  one-cycle pulse on handshake timeout.

## Operation
- dav_in, atn_in pass through 2-flop synchronisers (dav_s, atn_s). dio_in is sampled unsynchronised; the talker holds it stable while DAV=1.
- FSM states and registered outputs (nrfd_out, ndac_out):
  - HOLD (1,1): go to READY when listen_en=1, FIFO count < FIFO_DEPTH and dav_s=0.
  - READY (0,1): if dav_s=1, go to CAPTURE and latch {atn_s, dio_in}. Otherwise, if listen_en=0, go to HOLD.
  - CAPTURE (1,1): one cycle; push latched byte into FIFO; go to ACCEPT.
  - ACCEPT (1,0): if dav_s=0, go to HOLD. If the timeout counter reaches TIMEOUT_CYCLES, pulse timeout_err and go to HOLD.
- Slot reservation: READY is entered only with FIFO room. A pop can only add room, so the CAPTURE push never overflows and no byte is dropped.
- listen_en falling in CAPTURE or ACCEPT does not abort; the handshake completes, then the FSM stays in HOLD.
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit pointers; wrap at FIFO_DEPTH.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pop when empty is ignored.
- rx_data/rx_cmd reflect the head entry and are valid only while rx_valid=1.
- The timeout counter clears on ACCEPT entry and counts each cycle in ACCEPT.
- Reset values: state HOLD; nrfd_out=1, ndac_out=1, rx_valid=0, rx_data=0, rx_cmd=0, timeout_err=0; FIFO empty; synchronisers 0.
- Reset mid-handshake returns to the reset values immediately; FIFO contents are lost.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- dav_in rises, first sampled at edge k: dav_s=1 after k+1; nrfd_out=1 after k+2 (CAPTURE); ndac_out=0 and rx_valid=1 after k+3.
- dav_in falls, first sampled at edge m: ndac_out=1 after m+2. nrfd_out=0 after m+3 if room and listen_en=1.
- Minimum byte period: 6 cycles plus talker response time.
- timeout_err asserts on the edge where the count equals TIMEOUT_CYCLES; the FSM is in HOLD from that edge.

## Configuration
- GPIB_LISTENER_ATN_FILTER_EN defined: bytes with atn_s=1 complete the full handshake but are not pushed to the FIFO; rx_cmd is tied 0.
- Undefined: command bytes are pushed with rx_cmd=1.

## Test plan
- Reset: assert rst_n=0 mid-ACCEPT -> nrfd_out=1, ndac_out=1, rx_valid=0 immediately; HOLD after release.
- Single byte: listen_en=1, dio_in=0xA5, dav_in pulse -> nrfd_out/ndac_out sequence (0,1)->(1,1)->(1,0)->(1,1); rx_data=0xA5, rx_cmd=0.
- Full FIFO: send 5 bytes 0x01..0x05 with rx_ready=0, FIFO_DEPTH=4 -> 4 accepted, nrfd_out stays 1. One pop -> 5th accepted; reads give 0x01..0x05 in order.
- Simultaneous push/pop at count=2 -> count stays 2, no lost or duplicated byte.
- Timeout: hold dav_in=1, TIMEOUT_CYCLES=10 -> timeout_err single pulse 10 cycles after ACCEPT entry; ndac_out=1; no re-capture until dav_in falls.
- Command byte: atn_in=1, dio_in=0x3F -> rx_cmd=1 with 0x3F, or with GPIB_LISTENER_ATN_FILTER_EN handshake completes and rx_valid stays 0.
